// File: rtl/g4_table_update_writer.sv
// Insert/delete/modify engine for one G4 other-table write port: walks bucket chains,
// allocates slots and relinks tails. Optional readback check: define G4_WRITE_READBACK_EN.
module g4_table_update_writer #(
  parameter int INDEX_BIT_LEN    = 11,
  parameter int ENTRY_DATA_WIDTH = 60,
  parameter int TABLE_ENTRY_SIZE = 2047,
  parameter int FREE_BASE        = 1024,
  parameter int MAX_HOPS         = 64,
  parameter int COMMAND_BIT_LEN  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [COMMAND_BIT_LEN-1:0]  cmd_op,
  input  logic [INDEX_BIT_LEN-1:0]    cmd_head,
  input  logic [INDEX_BIT_LEN-1:0]    cmd_rule_id,
  input  logic [31:0]                 cmd_src_ip,
  output logic [INDEX_BIT_LEN-1:0]    tbl_index,
  output logic                        tbl_we,
  output logic [ENTRY_DATA_WIDTH-1:0] tbl_din,
  input  logic [ENTRY_DATA_WIDTH-1:0] tbl_rdata,
  output logic                        busy,
  output logic                        done,
  output logic [2:0]                  status,
  output logic [INDEX_BIT_LEN:0]      free_ptr
);

  localparam int NEXT_LSB = ENTRY_DATA_WIDTH - INDEX_BIT_LEN;
  localparam int RULE_LSB = NEXT_LSB - INDEX_BIT_LEN;
  localparam int PAD_W    = RULE_LSB - 32;
  localparam int HW       = $clog2(MAX_HOPS + 1);

  localparam logic [INDEX_BIT_LEN:0] MAX_INDEX = TABLE_ENTRY_SIZE[INDEX_BIT_LEN:0];
  localparam logic [INDEX_BIT_LEN:0] FREE_INIT = FREE_BASE[INDEX_BIT_LEN:0];
  localparam logic [HW-1:0]          HOP_MAX   = MAX_HOPS[HW-1:0];

  localparam logic [COMMAND_BIT_LEN-1:0] OP_NOP    = 2'b00;
  localparam logic [COMMAND_BIT_LEN-1:0] OP_INSERT = 2'b01;
  localparam logic [COMMAND_BIT_LEN-1:0] OP_MODIFY = 2'b11;

  localparam logic [2:0] ST_OK          = 3'b000;
  localparam logic [2:0] ST_NOT_FOUND   = 3'b001;
  localparam logic [2:0] ST_FULL        = 3'b010;
  localparam logic [2:0] ST_HOP_LIMIT   = 3'b011;
  localparam logic [2:0] ST_BAD_INDEX   = 3'b101;

`ifdef G4_WRITE_READBACK_EN
  localparam logic [2:0] ST_VERIFY_FAIL = 3'b100;
  typedef enum logic [3:0] {
    IDLE, READ, EVAL, WR_NEW, WR_LINK, WR_ENTRY, VFY_RD, VFY_CMP, DONE
  } state_t;
`else
  typedef enum logic [3:0] {
    IDLE, READ, EVAL, WR_NEW, WR_LINK, WR_ENTRY, DONE
  } state_t;
`endif

  state_t state_r, state_n;

  logic [COMMAND_BIT_LEN-1:0]  op_r;
  logic [INDEX_BIT_LEN-1:0]    rule_id_r;
  logic [31:0]                 key_r;
  logic [INDEX_BIT_LEN-1:0]    cur_r, cur_n;
  logic [HW-1:0]               hops_r, hops_n;
  logic [ENTRY_DATA_WIDTH-1:0] entry_r;
  logic [INDEX_BIT_LEN:0]      free_ptr_r, free_ptr_n;
  logic [2:0]                  status_r, status_n;
  logic                        done_r, cmd_ready_r, busy_r, tbl_we_r;
  logic [INDEX_BIT_LEN-1:0]    tbl_index_r, idx_n;
  logic [ENTRY_DATA_WIDTH-1:0] tbl_din_r, din_n;
  logic                        we_n;

  logic                        accept_s;
  logic                        bad_head_s;
  logic [INDEX_BIT_LEN:0]      head_ext_s;
  logic [ENTRY_DATA_WIDTH-1:0] entry_s;
  logic [INDEX_BIT_LEN-1:0]    next_s;
  logic                        match_s;

`ifdef G4_WRITE_READBACK_EN
  logic [ENTRY_DATA_WIDTH-1:0] wdata_r, wdata_n;
  logic                        after_new_r, after_new_n;
`endif

  assign accept_s   = cmd_valid && cmd_ready_r;
  assign head_ext_s = {1'b0, cmd_head};
  assign bad_head_s = (cmd_head == {INDEX_BIT_LEN{1'b0}}) || (head_ext_s > MAX_INDEX);
  // The tail entry is taken straight off the read port in EVAL, from the latch afterwards.
  assign entry_s    = (state_r == EVAL) ? tbl_rdata : entry_r;
  assign next_s     = tbl_rdata[ENTRY_DATA_WIDTH-1:NEXT_LSB];
  assign match_s    = (tbl_rdata[31:0] == key_r);

  // Next-state, walk bookkeeping and next-cycle table port values
  always_comb begin
    state_n    = state_r;
    cur_n      = cur_r;
    hops_n     = hops_r;
    status_n   = status_r;
    free_ptr_n = free_ptr_r;
`ifdef G4_WRITE_READBACK_EN
    after_new_n = after_new_r;
`endif
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          cur_n  = cmd_head;
          hops_n = {HW{1'b0}};
          if (cmd_op == OP_NOP) begin
            state_n  = DONE;
            status_n = ST_OK;
          end else if (bad_head_s) begin
            state_n  = DONE;
            status_n = ST_BAD_INDEX;
          end else begin
            state_n = READ;
          end
        end else begin
          state_n = IDLE;
        end
      end
      READ: begin
        hops_n  = hops_r + HW'(1);
        state_n = EVAL;
      end
      EVAL: begin
        if (op_r == OP_INSERT && next_s == {INDEX_BIT_LEN{1'b0}}) begin
          if (free_ptr_r <= MAX_INDEX) begin
            state_n = WR_NEW;
          end else begin
            state_n  = DONE;
            status_n = ST_FULL;
          end
        end else if (op_r != OP_INSERT && match_s) begin
          state_n = WR_ENTRY;
        end else if (op_r != OP_INSERT && next_s == {INDEX_BIT_LEN{1'b0}}) begin
          state_n  = DONE;
          status_n = ST_NOT_FOUND;
        end else if (hops_r == HOP_MAX) begin
          state_n  = DONE;
          status_n = ST_HOP_LIMIT;
        end else begin
          cur_n   = next_s;
          state_n = READ;
        end
      end
`ifdef G4_WRITE_READBACK_EN
      WR_NEW: begin
        after_new_n = 1'b1;
        state_n     = VFY_RD;
      end
      WR_LINK: begin
        free_ptr_n  = free_ptr_r + (INDEX_BIT_LEN+1)'(1);
        after_new_n = 1'b0;
        state_n     = VFY_RD;
      end
      WR_ENTRY: begin
        after_new_n = 1'b0;
        state_n     = VFY_RD;
      end
      VFY_RD: begin
        state_n = VFY_CMP;
      end
      VFY_CMP: begin
        if (tbl_rdata != wdata_r) begin
          state_n  = DONE;
          status_n = ST_VERIFY_FAIL;
        end else if (after_new_r) begin
          state_n = WR_LINK;
        end else begin
          state_n  = DONE;
          status_n = ST_OK;
        end
      end
`else
      WR_NEW: begin
        state_n = WR_LINK;
      end
      WR_LINK: begin
        free_ptr_n = free_ptr_r + (INDEX_BIT_LEN+1)'(1);
        state_n    = DONE;
        status_n   = ST_OK;
      end
      WR_ENTRY: begin
        state_n  = DONE;
        status_n = ST_OK;
      end
`endif
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    idx_n = {INDEX_BIT_LEN{1'b0}};
    we_n  = 1'b0;
    din_n = {ENTRY_DATA_WIDTH{1'b0}};
    case (state_n)
      READ: begin
        idx_n = cur_n;
      end
      WR_NEW: begin
        idx_n = free_ptr_r[INDEX_BIT_LEN-1:0];
        we_n  = 1'b1;
        din_n = {{INDEX_BIT_LEN{1'b0}}, rule_id_r, {PAD_W{1'b0}}, key_r};
      end
      WR_LINK: begin
        idx_n = cur_r;
        we_n  = 1'b1;
        din_n = {free_ptr_r[INDEX_BIT_LEN-1:0], entry_s[NEXT_LSB-1:0]};
      end
      WR_ENTRY: begin
        idx_n = cur_r;
        we_n  = 1'b1;
        if (op_r == OP_MODIFY) begin
          din_n = {entry_s[ENTRY_DATA_WIDTH-1:NEXT_LSB], rule_id_r, entry_s[RULE_LSB-1:0]};
        end else begin
          din_n = {entry_s[ENTRY_DATA_WIDTH-1:NEXT_LSB], {NEXT_LSB{1'b0}}};
        end
      end
`ifdef G4_WRITE_READBACK_EN
      VFY_RD: begin
        idx_n = tbl_index_r;
      end
`endif
      default: begin
        idx_n = {INDEX_BIT_LEN{1'b0}};
      end
    endcase
`ifdef G4_WRITE_READBACK_EN
    wdata_n = we_n ? din_n : wdata_r;
`endif
  end

  // State, command latches and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      op_r        <= {COMMAND_BIT_LEN{1'b0}};
      rule_id_r   <= {INDEX_BIT_LEN{1'b0}};
      key_r       <= 32'd0;
      cur_r       <= {INDEX_BIT_LEN{1'b0}};
      hops_r      <= {HW{1'b0}};
      entry_r     <= {ENTRY_DATA_WIDTH{1'b0}};
      free_ptr_r  <= FREE_INIT;
      status_r    <= 3'b000;
      done_r      <= 1'b0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      tbl_we_r    <= 1'b0;
      tbl_index_r <= {INDEX_BIT_LEN{1'b0}};
      tbl_din_r   <= {ENTRY_DATA_WIDTH{1'b0}};
`ifdef G4_WRITE_READBACK_EN
      wdata_r     <= {ENTRY_DATA_WIDTH{1'b0}};
      after_new_r <= 1'b0;
`endif
    end else begin
      state_r <= state_n;
      if (accept_s) begin
        op_r      <= cmd_op;
        rule_id_r <= cmd_rule_id;
        key_r     <= cmd_src_ip;
      end
      if (state_r == EVAL) begin
        entry_r <= tbl_rdata;
      end
      cur_r       <= cur_n;
      hops_r      <= hops_n;
      free_ptr_r  <= free_ptr_n;
      status_r    <= status_n;
      done_r      <= (state_n == DONE);
      cmd_ready_r <= (state_n == IDLE);
      busy_r      <= (state_n != IDLE);
      tbl_we_r    <= we_n;
      tbl_index_r <= idx_n;
      tbl_din_r   <= din_n;
`ifdef G4_WRITE_READBACK_EN
      wdata_r     <= wdata_n;
      after_new_r <= after_new_n;
`endif
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign status    = status_r;
  assign tbl_we    = tbl_we_r;
  assign tbl_index = tbl_index_r;
  assign tbl_din   = tbl_din_r;
  assign free_ptr  = free_ptr_r;

endmodule

// File: tb/tb_g4_table_update_writer.sv
// Directed bench for g4_table_update_writer with a registered-read table model.
module tb_g4_table_update_writer;

`ifdef G4_WRITE_READBACK_EN
  localparam int RB = 2;
`else
  localparam int RB = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [10:0] cmd_head = 11'd0;
  logic [10:0] cmd_rule_id = 11'd0;
  logic [31:0] cmd_src_ip = 32'd0;
  logic [10:0] tbl_index;
  logic        tbl_we;
  logic [59:0] tbl_din;
  logic [59:0] tbl_rdata;
  logic        busy;
  logic        done;
  logic [2:0]  status;
  logic [11:0] free_ptr;

  logic [59:0] mem [0:2047];
  logic [10:0] w_idx [0:7];
  logic [59:0] w_dat [0:7];
  int          wr_cnt;
  logic        corrupt = 1'b0;
  logic        we_d = 1'b0;

  int          vectors = 0;
  int          miscompares = 0;
  logic        last_rdy, last_busy;

  g4_table_update_writer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_head(cmd_head), .cmd_rule_id(cmd_rule_id), .cmd_src_ip(cmd_src_ip),
    .tbl_index(tbl_index), .tbl_we(tbl_we), .tbl_din(tbl_din), .tbl_rdata(tbl_rdata),
    .busy(busy), .done(done), .status(status), .free_ptr(free_ptr)
  );

  always #5 clk = ~clk;

  // Table model: read-first registered read port, write log, optional readback corruption
  always @(posedge clk) begin
    tbl_rdata <= mem[tbl_index] ^ ((corrupt && we_d) ? 60'd1 : 60'd0);
    we_d      <= tbl_we;
    if (tbl_we) begin
      if (wr_cnt < 8) begin
        w_idx[wr_cnt] = tbl_index;
        w_dat[wr_cnt] = tbl_din;
      end
      wr_cnt = wr_cnt + 1;
      mem[tbl_index] = tbl_din;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [10:0] head, input logic [10:0] rule,
                         input logic [31:0] ip, output int lat, output logic [2:0] st);
    int guard;
    guard = 0;
    while (!cmd_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    wr_cnt      = 0;
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_head    = head;
    cmd_rule_id = rule;
    cmd_src_ip  = ip;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    last_rdy  = cmd_ready;
    last_busy = busy;
    lat = 1;
    while (!done && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    st = status;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    logic [2:0] st;
    int errs;
    logic [10:0] h;

    for (int i = 0; i < 2048; i++) mem[i] = 60'd0;
    wr_cnt = 0;
    mem[5] = {11'd0, 11'd7, 6'd0, 32'h01010101};

    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_status", {61'd0, status}, 64'd0);
    check("rst_tbl_we", {63'd0, tbl_we}, 64'd0);
    check("rst_tbl_index", {53'd0, tbl_index}, 64'd0);
    check("rst_tbl_din", {4'd0, tbl_din}, 64'd0);
    check("rst_free_ptr", {52'd0, free_ptr}, 64'd1024);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // INSERT on a single-entry chain
    run_cmd(2'b01, 11'd5, 11'h2A, 32'h0A000001, lat, st);
    check("ins_lat", 64'(lat), 64'(5 + 2 * RB));
    check("ins_status", {61'd0, st}, 64'd0);
    check("ins_wr_cnt", 64'(wr_cnt), 64'd2);
    check("ins_new_idx", {53'd0, w_idx[0]}, 64'd1024);
    check("ins_new_dat", {4'd0, w_dat[0]}, {4'd0, 11'd0, 11'h2A, 6'd0, 32'h0A000001});
    check("ins_link_idx", {53'd0, w_idx[1]}, 64'd5);
    check("ins_link_dat", {4'd0, w_dat[1]}, {4'd0, 11'd1024, 11'd7, 6'd0, 32'h01010101});
    check("ins_free_ptr", {52'd0, free_ptr}, 64'd1025);

    // MODIFY second entry on chain 5 -> 9
    mem[5] = {11'd9, 11'd7, 6'd0, 32'h01010101};
    mem[9] = {11'd0, 11'd3, 6'd0, 32'hC0A80001};
    run_cmd(2'b11, 11'd5, 11'h11, 32'hC0A80001, lat, st);
    check("mod_lat", 64'(lat), 64'(6 + RB));
    check("mod_status", {61'd0, st}, 64'd0);
    check("mod_wr_cnt", 64'(wr_cnt), 64'd1);
    check("mod_idx", {53'd0, w_idx[0]}, 64'd9);
    check("mod_dat", {4'd0, w_dat[0]}, {4'd0, 11'd0, 11'h11, 6'd0, 32'hC0A80001});

    // DELETE of an absent key
    run_cmd(2'b10, 11'd5, 11'h0, 32'hDEADBEEF, lat, st);
    check("del_miss_lat", 64'(lat), 64'd5);
    check("del_miss_status", {61'd0, st}, 64'd1);
    check("del_miss_wr_cnt", 64'(wr_cnt), 64'd0);

    // DELETE at the head leaves a tombstone keeping next
    run_cmd(2'b10, 11'd5, 11'h0, 32'h01010101, lat, st);
    check("del_lat", 64'(lat), 64'(4 + RB));
    check("del_status", {61'd0, st}, 64'd0);
    check("del_wr_cnt", 64'(wr_cnt), 64'd1);
    check("del_idx", {53'd0, w_idx[0]}, 64'd5);
    check("del_dat", {4'd0, w_dat[0]}, {4'd0, 11'd9, 49'd0});

    run_cmd(2'b00, 11'd5, 11'h0, 32'h0, lat, st);
    check("nop_lat", 64'(lat), 64'd1);
    check("nop_status", {61'd0, st}, 64'd0);

    run_cmd(2'b01, 11'd0, 11'h1, 32'h1, lat, st);
    check("bad_lat", 64'(lat), 64'd1);
    check("bad_status", {61'd0, st}, 64'd5);
    check("bad_wr_cnt", 64'(wr_cnt), 64'd0);
    check("bad_ready_low", {63'd0, last_rdy}, 64'd0);
    check("bad_busy_high", {63'd0, last_busy}, 64'd1);

`ifdef G4_WRITE_READBACK_EN
    corrupt = 1'b1;
    run_cmd(2'b11, 11'd9, 11'h22, 32'hC0A80001, lat, st);
    corrupt = 1'b0;
    check("vfy_lat", 64'(lat), 64'd6);
    check("vfy_status", {61'd0, st}, 64'd4);
`endif

    // Cyclic chain 5 -> 9 -> 5 runs into the hop limit
    mem[5] = {11'd9, 11'd7, 6'd0, 32'h01010101};
    mem[9] = {11'd5, 11'd3, 6'd0, 32'h02020202};
    run_cmd(2'b11, 11'd5, 11'h11, 32'h12345678, lat, st);
    check("hop_lat", 64'(lat), 64'd129);
    check("hop_status", {61'd0, st}, 64'd3);
    check("hop_wr_cnt", 64'(wr_cnt), 64'd0);

    // Reset in the middle of a walk
    wr_cnt      = 0;
    cmd_valid   = 1'b1;
    cmd_op      = 2'b11;
    cmd_head    = 11'd5;
    cmd_src_ip  = 32'h12345678;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_busy_before", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {63'd0, cmd_ready}, 64'd1);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_index", {53'd0, tbl_index}, 64'd0);
    check("mid_rst_we", {63'd0, tbl_we}, 64'd0);
    check("mid_rst_free_ptr", {52'd0, free_ptr}, 64'd1024);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_post_busy", {63'd0, busy}, 64'd0);
    check("mid_post_wr_cnt", 64'(wr_cnt), 64'd0);

    // Fill the allocation region, always appending to the newest tail
    mem[3] = {11'd0, 11'd1, 6'd0, 32'hFFFFFFFF};
    h = 11'd3;
    errs = 0;
    for (int i = 0; i < 1024; i++) begin
      run_cmd(2'b01, h, 11'h1, 32'(i), lat, st);
      if (st != 3'b000 || lat != 5 + 2 * RB) errs++;
      h = 11'(1024 + i);
    end
    check("fill_errors", 64'(errs), 64'd0);
    check("fill_free_ptr", {52'd0, free_ptr}, 64'd2048);

    run_cmd(2'b01, 11'd2047, 11'h5, 32'h55, lat, st);
    check("full_lat", 64'(lat), 64'd3);
    check("full_status", {61'd0, st}, 64'd2);
    check("full_wr_cnt", 64'(wr_cnt), 64'd0);
    check("full_free_ptr", {52'd0, free_ptr}, 64'd2048);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/g4_table_update_writer.md
# g4_table_update_writer

Update engine that drives the write port of a G4 protocol-other search table. It accepts insert/delete/modify commands for 60-bit chained entries, walks the chain from a bucket head through the table's registered read path, allocates free slots, writes new entries, and relinks chain tails. It sits between the rule-update command source and one G4 other-table instance, sharing that table's index port with the search path while `busy` is high.

## Interface
- `INDEX_BIT_LEN`, 11, table index width; also the width of the next-pointer and ruleID fields.
- `ENTRY_DATA_WIDTH`, 60, entry width: [59:49] next, [48:38] ruleID, [37:32] zero pad, [31:0] srcIP.
- `TABLE_ENTRY_SIZE`, 2047, highest valid table index.
- `FREE_BASE`, 1024, first index of the allocation region.
- `MAX_HOPS`, 64, chain-walk limit per command.
- `COMMAND_BIT_LEN`, 2, opcode width.

Ports:
- `clk`, in, 1, rising-edge clock.
- `rst_n`, in, 1, asynchronous active-low reset.
- `cmd_valid`, in, 1, command present.
- `cmd_ready`, out, 1, engine idle; the command is accepted when `cmd_valid && cmd_ready`.
- `cmd_op`, in, COMMAND_BIT_LEN, opcode: 00 NOP, 01 INSERT, 10 DELETE, 11 MODIFY.
- `cmd_head`, in, INDEX_BIT_LEN, chain head index.
- `cmd_rule_id`, in, INDEX_BIT_LEN, ruleID to write.
- `cmd_src_ip`, in, 32, key.
- `tbl_index`, out, INDEX_BIT_LEN, table index.
- `tbl_we`, out, 1, table write enable.
- `tbl_din`, out, ENTRY_DATA_WIDTH, table write data.
- `tbl_rdata`, in, ENTRY_DATA_WIDTH, full entry at `tbl_index`, valid one cycle after the index is driven.
- `busy`, out, 1, engine owns the table index.
- `done`, out, 1, one-cycle completion pulse.
- `status`, out, 3, result, valid while `done` is high: 000 OK, 001 NOT_FOUND, 010 FULL, 011 HOP_LIMIT, 100 VERIFY_FAIL, 101 BAD_INDEX.
- `free_ptr`, out, INDEX_BIT_LEN+1, next allocation index.

## Operation
- States: IDLE, READ, EVAL, WR_NEW, WR_LINK, WR_ENTRY, (VERIFY), DONE.
- IDLE:
  - `cmd_ready` = 1.
  - On accept, latch the command fields and set cur = `cmd_head`, hops = 0.
  - NOP goes directly to DONE with status OK.
  - `cmd_head` == 0 or > TABLE_ENTRY_SIZE goes to DONE with status BAD_INDEX. Index 0 is the null pointer.
- READ: drive `tbl_index` = cur, `tbl_we` = 0, increment hops.
- EVAL: sample `tbl_rdata`.
  - INSERT:
    - If next != 0, set cur = next and return to READ.
    - If next == 0, this entry is the tail. Go to WR_NEW if `free_ptr` <= TABLE_ENTRY_SIZE, otherwise go to DONE with status FULL.
  - DELETE/MODIFY:
    - If srcIP == key, go to WR_ENTRY.
    - Else if next == 0, go to DONE with status NOT_FOUND.
    - Else set cur = next and return to READ.
  - If hops == MAX_HOPS and the walk would continue, go to DONE with status HOP_LIMIT.
- WR_NEW: write {0, rule_id, 6'b0, key} at `free_ptr`.
- WR_LINK:
  - Write the latched tail entry with its next field replaced by `free_ptr` at index cur.
  - Increment `free_ptr` at the end of this state.
- WR_ENTRY:
  - MODIFY: write the latched entry with ruleID = `cmd_rule_id`.
  - DELETE: write the latched entry with ruleID and srcIP zeroed and next preserved (tombstone).
- DONE: pulse `done`, then go to IDLE.
- `free_ptr` never decrements. Tombstones are not reclaimed.

## Timing
- Reset values:
  - state IDLE
  - `cmd_ready` 1
  - `busy` 0
  - `done` 0
  - `status` 000
  - `tbl_we` 0
  - `tbl_index` 0
  - `tbl_din` 0
  - `free_ptr` FREE_BASE
- Reset asserted mid-command aborts the command with no further writes. A partially linked insert is the system's responsibility.
- Each hop costs 2 cycles (READ, EVAL).
- INSERT latency from accept to `done`: 2·hops + 3 cycles.
- DELETE/MODIFY latency: 2·hops + 2 cycles.
- NOP/BAD_INDEX latency: `done` is 1 cycle after accept.
- `cmd_ready` is low from the cycle after accept through DONE. A new command can be accepted in the cycle after `done`.
- `busy` = !IDLE. `tbl_we` is high only in WR_* states, for exactly one cycle each.
- `cmd_valid` arriving during DONE is not accepted until IDLE.

## Configuration
- `G4_WRITE_READBACK_EN`:
  - When defined, every write state is followed by a VERIFY state (2 cycles: re-read the written index, compare against the written data). A mismatch goes to DONE with status VERIFY_FAIL and aborts any remaining writes. Each write adds 2 cycles of latency.
  - When undefined, there is no VERIFY state and status 100 is never produced.

## Test plan
- Reset with `rst_n` = 0 mid-walk, release -> all outputs at their reset values, `free_ptr` = 1024, `cmd_ready` = 1.
- INSERT, head = 5, table[5].next = 0, rule 0x2A, ip 0x0A000001 -> write at 1024 of {0, 0x2A, 0, 0x0A000001}, then write table[5] with next = 1024, `done` with status 000 at cycle 5, `free_ptr` = 1025.
- MODIFY along chain 5 → 9 → 0, where table[9].srcIP = 0xC0A80001, rule 0x11 -> single write at 9 with ruleID 0x11 and next/srcIP unchanged, status 000, latency 6.
- DELETE of an absent IP on chain 5 → 9 -> no `tbl_we`, status 001.
- `free_ptr` = 2048, INSERT -> no writes, status 010. Cyclic chain 5 → 9 → 5 -> status 011 after 64 hops.
- With the macro defined, force `tbl_rdata` corruption on readback -> status 100.
- `cmd_head` = 0 -> status 101, 1 cycle.
